// File: rtl/ibex_trace_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_trace_event_arbiter
// Description : Merges IF and ID/EX trace events into one ordered, timestamped
//               stream with FIFO buffering and in-order LOST drop markers.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_trace_event_arbiter #(
    parameter int DEPTH = 8,
    parameter int CYC_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trace_en,
    input  logic                       if_evt,
    input  logic [1:0]                 if_kind,
    input  logic [31:0]                if_pc,
    input  logic [31:0]                if_insn,
    input  logic                       if_c,
    input  logic [15:0]                if_c_insn,
    input  logic                       ex_evt,
    input  logic                       ex_kind,
    input  logic [31:0]                ex_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_kind,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_insn,
    output logic                       out_c,
    output logic [15:0]                out_c_insn,
    output logic [CYC_W-1:0]           out_cycle,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       ovf_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [2:0] c_kind_idex = 3'd3;
    localparam logic [2:0] c_kind_lost = 3'd5;

    typedef struct packed {
        logic [2:0]       kind;
        logic [31:0]      pc;
        logic [31:0]      insn;
        logic             c;
        logic [15:0]      c_insn;
        logic [CYC_W-1:0] cycle;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [CYC_W-1:0]   r_cyc;
    logic [15:0]        r_lost_cnt;
    logic               r_lost_pending;
    logic               r_ovf;

    logic               w_if_req;
    logic               w_ex_req;
    logic [1:0]         w_req_cnt;
    logic [LVL_W-1:0]   w_free;
    logic               w_pop;
    logic [16:0]        w_pend_sum;
    logic [15:0]        w_pend_sat;
    logic [16:0]        w_drop_sum;
    logic [15:0]        w_drop_sat;
    entry_t             w_if_ent;
    entry_t             w_ex_ent;
    entry_t             w_lost_ent;
    entry_t             w_ent0;
    entry_t             w_ent1;
    logic               w_push0;
    logic               w_push1;
    logic [1:0]         w_drops;
    logic               w_lost_clear;
    logic [LVL_W-1:0]   w_n_push;
    entry_t             w_head;

    assign w_if_req  = trace_en & if_evt;
    assign w_ex_req  = trace_en & ex_evt;
    assign w_req_cnt = {1'b0, w_if_req} + {1'b0, w_ex_req};
    // Free space is taken at cycle start; a same-cycle pop does not help pushes.
    assign w_free    = LVL_W'(DEPTH) - r_level;
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid & out_ready;

    assign w_pend_sum = {1'b0, r_lost_cnt} + {15'd0, w_req_cnt};
    assign w_pend_sat = w_pend_sum[16] ? 16'hFFFF : w_pend_sum[15:0];

    assign w_if_ent   = '{kind: {1'b0, if_kind}, pc: if_pc, insn: if_insn,
                          c: if_c, c_insn: if_c_insn, cycle: r_cyc};
    assign w_ex_ent   = '{kind: c_kind_idex + {2'b00, ex_kind}, pc: ex_pc, insn: 32'd0,
                          c: 1'b0, c_insn: 16'd0, cycle: r_cyc};
    assign w_lost_ent = '{kind: c_kind_lost, pc: {16'd0, w_pend_sat}, insn: 32'd0,
                          c: 1'b0, c_insn: 16'd0, cycle: r_cyc};

    always_comb begin
        w_push0      = 1'b0;
        w_push1      = 1'b0;
        w_ent0       = w_if_ent;
        w_ent1       = w_ex_ent;
        w_drops      = 2'd0;
        w_lost_clear = 1'b0;
        if (r_lost_pending) begin
            // Everything presented while a marker is owed is dropped and folded into it.
            w_drops = w_req_cnt;
            if (w_free != '0) begin
                w_push0      = 1'b1;
                w_ent0       = w_lost_ent;
                w_lost_clear = 1'b1;
            end
        end else if (w_free >= LVL_W'(2)) begin
            if (w_if_req) begin
                w_push0 = 1'b1;
                w_push1 = w_ex_req;
            end else if (w_ex_req) begin
                w_push0 = 1'b1;
                w_ent0  = w_ex_ent;
            end
        end else if (w_free == LVL_W'(1)) begin
            if (w_if_req) begin
                w_push0 = 1'b1;
                w_drops = {1'b0, w_ex_req};
            end else if (w_ex_req) begin
                w_push0 = 1'b1;
                w_ent0  = w_ex_ent;
            end
        end else begin
            w_drops = w_req_cnt;
        end
    end

    assign w_n_push   = LVL_W'(w_push0) + LVL_W'(w_push1);
    assign w_drop_sum = {1'b0, r_lost_cnt} + {15'd0, w_drops};
    assign w_drop_sat = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_cyc          <= '0;
            r_lost_cnt     <= 16'd0;
            r_lost_pending <= 1'b0;
            r_ovf          <= 1'b0;
        end else begin
            r_cyc    <= r_cyc + CYC_W'(1);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= r_level + w_n_push - LVL_W'(w_pop);
            if (w_lost_clear) begin
                r_lost_cnt     <= 16'd0;
                r_lost_pending <= 1'b0;
            end else if (w_drops != 2'd0) begin
                r_lost_cnt     <= w_drop_sat;
                r_lost_pending <= 1'b1;
            end
            if (w_drops != 2'd0) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_push0) begin
                r_mem[r_wr_ptr] <= w_ent0;
            end
            if (w_push1) begin
                r_mem[r_wr_ptr + PTR_W'(1)] <= w_ent1;
            end
        end
    end

    assign w_head     = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_kind   = w_head.kind;
    assign out_pc     = w_head.pc;
    assign out_insn   = w_head.insn;
    assign out_c      = w_head.c;
    assign out_c_insn = w_head.c_insn;
    assign out_cycle  = w_head.cycle;
    assign fifo_level = r_level;
    assign ovf_sticky = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ibex_trace_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_trace_event_arbiter
// Description : Scoreboard bench for ibex_trace_event_arbiter (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_trace_event_arbiter;

    logic        clk;
    logic        rst_n;
    logic        trace_en;
    logic        if_evt;
    logic [1:0]  if_kind;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        if_c;
    logic [15:0] if_c_insn;
    logic        ex_evt;
    logic        ex_kind;
    logic [31:0] ex_pc;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_insn;
    logic        out_c;
    logic [15:0] out_c_insn;
    logic [31:0] out_cycle;
    logic [3:0]  fifo_level;
    logic        ovf_sticky;

    ibex_trace_event_arbiter #(.DEPTH(8), .CYC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en),
        .if_evt(if_evt), .if_kind(if_kind), .if_pc(if_pc), .if_insn(if_insn),
        .if_c(if_c), .if_c_insn(if_c_insn),
        .ex_evt(ex_evt), .ex_kind(ex_kind), .ex_pc(ex_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_insn(out_insn), .out_c(out_c), .out_c_insn(out_c_insn),
        .out_cycle(out_cycle), .fifo_level(fifo_level), .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        c;
        logic [15:0] ci;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] tb_cyc;

    // Cycle number seen by events driven in the current cycle.
    always @(posedge clk) tb_cyc <= !rst_n ? 32'd0 : tb_cyc + 32'd1;

    exp_t prev;
    bit   stalled_prev = 1'b0;

    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = '{kind: out_kind, pc: out_pc, insn: out_insn, c: out_c, ci: out_c_insn, cyc: out_cycle};
        if (rst_n) begin
            if (stalled_prev && out_valid) begin
                tests++;
                if (cur != prev) begin
                    fails++;
                    $display("FAIL stall_hold: got kind %0d pc 0x%0h cyc %0d, required kind %0d pc 0x%0h cyc %0d",
                             cur.kind, cur.pc, cur.cyc, prev.kind, prev.pc, prev.cyc);
                end
            end
            stalled_prev = out_valid && !out_ready;
            prev = cur;
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL pop_unexpected: got kind %0d pc 0x%0h cyc %0d, required no entry",
                             cur.kind, cur.pc, cur.cyc);
                end else begin
                    e = q.pop_front();
                    if (cur != e) begin
                        fails++;
                        $display("FAIL pop: got kind %0d pc 0x%0h insn 0x%0h c %0d ci 0x%0h cyc %0d, required kind %0d pc 0x%0h insn 0x%0h c %0d ci 0x%0h cyc %0d",
                                 cur.kind, cur.pc, cur.insn, cur.c, cur.ci, cur.cyc,
                                 e.kind, e.pc, e.insn, e.c, e.ci, e.cyc);
                    end
                end
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_if(input bit v, input logic [1:0] k, input logic [31:0] pc,
                          input logic [31:0] insn, input logic c, input logic [15:0] ci);
        if_evt = v; if_kind = k; if_pc = pc; if_insn = insn; if_c = c; if_c_insn = ci;
    endtask

    task automatic set_ex(input bit v, input logic k, input logic [31:0] pc);
        ex_evt = v; ex_kind = k; ex_pc = pc;
    endtask

    task automatic exp_if(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] insn,
                          input logic c, input logic [15:0] ci, input logic [31:0] cyc);
        q.push_back('{kind: {1'b0, k}, pc: pc, insn: insn, c: c, ci: ci, cyc: cyc});
    endtask

    task automatic exp_ex(input logic k, input logic [31:0] pc, input logic [31:0] cyc);
        q.push_back('{kind: (k ? 3'd4 : 3'd3), pc: pc, insn: 32'd0, c: 1'b0, ci: 16'd0, cyc: cyc});
    endtask

    task automatic exp_lost(input logic [31:0] cnt, input logic [31:0] cyc);
        q.push_back('{kind: 3'd5, pc: cnt, insn: 32'd0, c: 1'b0, ci: 16'd0, cyc: cyc});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        logic [31:0] n;
        rst_n = 1'b0; trace_en = 1'b1; out_ready = 1'b0;
        set_if(0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        set_ex(0, 1'b0, 32'd0);
        step(2);
        rst_n = 1'b1;

        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_level", {60'd0, fifo_level}, 64'd0);
        check("rst_ovf", {63'd0, ovf_sticky}, 64'd0);
        check("rst_pc", {32'd0, out_pc}, 64'd0);

        // Dual event into empty FIFO: IF first, both stamped with the push cycle.
        out_ready = 1'b1;
        n = tb_cyc;
        set_if(1, 2'd0, 32'h80, 32'h13, 1'b0, 16'd0);
        set_ex(1, 1'b0, 32'h7C);
        exp_if(2'd0, 32'h80, 32'h13, 1'b0, 16'd0, n);
        exp_ex(1'b0, 32'h7C, n);
        step();
        set_if(0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        set_ex(0, 1'b0, 32'd0);
        check("t1_lat_valid", {63'd0, out_valid}, 64'd1);
        check("t1_lat_pc", {32'd0, out_pc}, 64'h80);
        step();
        check("t1_second_kind", {61'd0, out_kind}, 64'd3);
        step();
        check("t1_empty", {63'd0, out_valid}, 64'd0);

        // Overflow under back-pressure, then LOST carries all drops incl. pending-period ones.
        out_ready = 1'b0;
        n = tb_cyc;
        for (int i = 0; i < 5; i++) begin
            set_if(1, 2'(i % 3), 32'h100 + 32'(8 * i), 32'h1000 + 32'(i), 1'(i & 1), 16'h4000 + 16'(i));
            set_ex(1, 1'(i % 2), 32'h104 + 32'(8 * i));
            if (i < 4) begin
                exp_if(2'(i % 3), 32'h100 + 32'(8 * i), 32'h1000 + 32'(i), 1'(i & 1), 16'h4000 + 16'(i), n + 32'(i));
                exp_ex(1'(i % 2), 32'h104 + 32'(8 * i), n + 32'(i));
            end
            step();
        end
        check("t2_level_full", {60'd0, fifo_level}, 64'd8);
        check("t2_ovf", {63'd0, ovf_sticky}, 64'd1);
        out_ready = 1'b1;
        set_if(1, 2'd0, 32'h200, 32'h0, 1'b0, 16'd0);
        set_ex(0, 1'b0, 32'd0);
        step();
        set_if(0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        exp_lost(32'd3, n + 32'd6);
        step(12);
        check("t2_drained", 64'(q.size()), 64'd0);
        check("t2_level0", {60'd0, fifo_level}, 64'd0);

        // free==1 with dual event: IF kept, IDEX dropped.
        do_reset();
        out_ready = 1'b0;
        n = tb_cyc;
        for (int i = 0; i < 7; i++) begin
            set_if(1, 2'd1, 32'h300 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0, 16'd0);
            exp_if(2'd1, 32'h300 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0, 16'd0, n + 32'(i));
            step();
        end
        check("t3_level7", {60'd0, fifo_level}, 64'd7);
        set_if(1, 2'd2, 32'h400, 32'h3000, 1'b1, 16'h5555);
        set_ex(1, 1'b1, 32'h404);
        exp_if(2'd2, 32'h400, 32'h3000, 1'b1, 16'h5555, n + 32'd7);
        step();
        set_if(0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        set_ex(0, 1'b0, 32'd0);
        check("t3_level8", {60'd0, fifo_level}, 64'd8);
        check("t3_ovf", {63'd0, ovf_sticky}, 64'd1);
        out_ready = 1'b1;
        step();
        exp_lost(32'd1, n + 32'd9);
        step(10);
        check("t3_drained", 64'(q.size()), 64'd0);

        // Ready toggling 1010 with one IF per cycle: FIFO fills at k=13, then
        // drop / LOST(2) alternate on k=14..19.
        do_reset();
        n = tb_cyc;
        for (int k = 0; k < 20; k++) begin
            out_ready = (k % 2 == 0);
            set_if(1, 2'd0, 32'h500 + 32'(4 * k), 32'h6000 + 32'(k), 1'b0, 16'd0);
            if (k <= 13) exp_if(2'd0, 32'h500 + 32'(4 * k), 32'h6000 + 32'(k), 1'b0, 16'd0, n + 32'(k));
            if (k == 15 || k == 17 || k == 19) exp_lost(32'd2, n + 32'(k));
            step();
        end
        set_if(0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        out_ready = 1'b1;
        step(12);
        check("t4_drained", 64'(q.size()), 64'd0);
        check("t4_level0", {60'd0, fifo_level}, 64'd0);

        // Reset mid-stream: buffer discarded, no LOST, counter restarts at 0.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_if(1, 2'd0, 32'h600 + 32'(4 * i), 32'h7000, 1'b0, 16'd0);
            step();
        end
        set_if(0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        check("t5_level5", {60'd0, fifo_level}, 64'd5);
        check("t5_ovf_before", {63'd0, ovf_sticky}, 64'd1);
        do_reset();
        check("t5_level0", {60'd0, fifo_level}, 64'd0);
        check("t5_valid0", {63'd0, out_valid}, 64'd0);
        check("t5_ovf0", {63'd0, ovf_sticky}, 64'd0);
        out_ready = 1'b1;
        set_if(1, 2'd1, 32'h700, 32'h8000, 1'b1, 16'h1234);
        exp_if(2'd1, 32'h700, 32'h8000, 1'b1, 16'h1234, 32'd0);
        step();
        set_if(0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        step(4);
        check("t5_drained", 64'(q.size()), 64'd0);

        // trace_en=0: events ignored entirely.
        trace_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_if(1, 2'd0, 32'h900 + 32'(4 * i), 32'h13, 1'b0, 16'd0);
            set_ex(1, 1'b0, 32'h904 + 32'(4 * i));
            step();
            check("t6_valid0", {63'd0, out_valid}, 64'd0);
        end
        check("t6_level0", {60'd0, fifo_level}, 64'd0);
        check("t6_ovf0", {63'd0, ovf_sticky}, 64'd0);
        set_if(0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        set_ex(0, 1'b0, 32'd0);
        trace_en = 1'b1;
        step(3);
        check("final_queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
